// File: rtl/ct_ciu_bmbif_rr_arb_if.sv
// BMB arbiter bundle: per-PIU request/grant plus the single queued bar channel.
// Handshake: a PIU holds req (and its payload) until it sees grant in the same cycle; the bar
// request holds until xx_bmbif_bar_grant, and a bar grant while bar_req is low is ignored.
interface ct_ciu_bmbif_rr_arb_if #(
  parameter int NUM_PIU = 4,
  parameter int BUS_W   = 9,
  parameter int DEPTH   = 4,
  parameter int MID_W   = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_PIU-1:0]       piu_bmbif_xx_req;
  logic [NUM_PIU*BUS_W-1:0] piu_bmbif_req_bus;
  logic [NUM_PIU-1:0]       bmbif_piu_xx_grant;
  logic                     bmbif_xx_bar_req;
  logic [BUS_W-1:0]         bmbif_xx_req_bus;
  logic [MID_W-1:0]         bmbif_xx_mid;
  logic                     xx_bmbif_bar_grant;
  logic [CNT_W-1:0]         bmbif_xx_fifo_cnt;
  logic                     bmbif_xx_idle;

  modport slave (
    input  piu_bmbif_xx_req, piu_bmbif_req_bus, xx_bmbif_bar_grant,
    output bmbif_piu_xx_grant, bmbif_xx_bar_req, bmbif_xx_req_bus, bmbif_xx_mid,
           bmbif_xx_fifo_cnt, bmbif_xx_idle
  );

  modport master (
    output piu_bmbif_xx_req, piu_bmbif_req_bus, xx_bmbif_bar_grant,
    input  bmbif_piu_xx_grant, bmbif_xx_bar_req, bmbif_xx_req_bus, bmbif_xx_mid,
           bmbif_xx_fifo_cnt, bmbif_xx_idle
  );
endinterface

// File: rtl/ct_ciu_bmbif_rr_arb.sv
// Round-robin arbiter of NUM_PIU requesters feeding an in-order DEPTH-entry queue whose head
// drives the single BMB bar request; grants stall while the queue is full and not popping.
module ct_ciu_bmbif_rr_arb #(
  parameter int NUM_PIU = 4,
  parameter int BUS_W   = 9,
  parameter int DEPTH   = 4,
  parameter int MID_W   = 3
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  ciu_icg_en,
  input  logic                  pad_yy_icg_scan_en,
  ct_ciu_bmbif_rr_arb_if.slave  bmb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = $clog2(NUM_PIU);

  logic [RR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic [BUS_W-1:0] q_bus [DEPTH];
  logic [MID_W-1:0] q_mid [DEPTH];

  logic               empty;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               clk_en;
  logic               gnt_vld;
  logic [RR_W-1:0]    gnt_idx;
  logic [RR_W-1:0]    nxt_ptr;
  logic [RR_W-1:0]    idx;
  logic [NUM_PIU-1:0] grant;
  logic [BUS_W-1:0]   gnt_bus;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign pop     = !empty && bmb.xx_bmbif_bar_grant;
  assign push_ok = !full || pop;
  // State only moves with a request or a non-empty queue, so this enable never changes timing.
  assign clk_en  = (|bmb.piu_bmbif_xx_req) || !empty || ciu_icg_en || pad_yy_icg_scan_en;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    grant   = '0;
    if (push_ok) begin
      for (int k = 0; k < NUM_PIU; k++) begin
        idx = RR_W'((int'(rr_ptr) + k) % NUM_PIU);
        if (!gnt_vld && bmb.piu_bmbif_xx_req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_bus = '0;
    for (int i = 0; i < NUM_PIU; i++) begin
      if (gnt_idx == RR_W'(i)) gnt_bus = bmb.piu_bmbif_req_bus[i*BUS_W +: BUS_W];
    end
  end

  // Explicit wrap so non-power-of-2 NUM_PIU returns to PIU0 after the last port.
  assign nxt_ptr = (gnt_idx == RR_W'(NUM_PIU - 1)) ? '0 : gnt_idx + RR_W'(1);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_ptr <= '0;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_bus[i] <= '0;
        q_mid[i] <= '0;
      end
    end else if (clk_en) begin
      if (gnt_vld) begin
        rr_ptr      <= nxt_ptr;
        q_bus[wptr] <= gnt_bus;
        q_mid[wptr] <= MID_W'(gnt_idx);
        wptr        <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({gnt_vld, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bmb.bmbif_piu_xx_grant = grant;
  assign bmb.bmbif_xx_bar_req   = !empty;
  assign bmb.bmbif_xx_req_bus   = empty ? '0 : q_bus[rptr];
  assign bmb.bmbif_xx_mid       = empty ? '0 : q_mid[rptr];
  assign bmb.bmbif_xx_fifo_cnt  = cnt;
  assign bmb.bmbif_xx_idle      = empty && !(|bmb.piu_bmbif_xx_req);

  a_grant_onehot0: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    $onehot0(grant));
  a_no_push_full: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(gnt_vld && full && !pop));
  a_cnt_range: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    cnt <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_ct_ciu_bmbif_rr_arb.sv
// Directed bench for the BMB round-robin arbiter: default 4-port build plus a 3-port/depth-8 build.
module tb_ct_ciu_bmbif_rr_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic icg_en = 1'b0;
  logic scan_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  ct_ciu_bmbif_rr_arb_if #(.NUM_PIU(4), .BUS_W(9), .DEPTH(4), .MID_W(3)) bif ();
  ct_ciu_bmbif_rr_arb #(.NUM_PIU(4), .BUS_W(9), .DEPTH(4), .MID_W(3)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .ciu_icg_en(icg_en),
    .pad_yy_icg_scan_en(scan_en), .bmb(bif));

  ct_ciu_bmbif_rr_arb_if #(.NUM_PIU(3), .BUS_W(16), .DEPTH(8), .MID_W(3)) b3 ();
  ct_ciu_bmbif_rr_arb #(.NUM_PIU(3), .BUS_W(16), .DEPTH(8), .MID_W(3)) dut3 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .ciu_icg_en(icg_en),
    .pad_yy_icg_scan_en(scan_en), .bmb(b3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input int i, input logic [8:0] v);
    bif.piu_bmbif_req_bus[i*9 +: 9] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.piu_bmbif_xx_req = '0;
    bif.piu_bmbif_req_bus = '0;
    bif.xx_bmbif_bar_grant = 1'b0;
    b3.piu_bmbif_xx_req = '0;
    b3.piu_bmbif_req_bus = '0;
    b3.xx_bmbif_bar_grant = 1'b0;
    step();
    step();
    n_tests++; if (bif.bmbif_xx_bar_req !== 1'b0) begin n_fail++; $display("FAIL reset_bar_req got %b exp 0", bif.bmbif_xx_bar_req); end
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", bif.bmbif_xx_fifo_cnt); end
    n_tests++; if (bif.bmbif_xx_req_bus !== 9'h0) begin n_fail++; $display("FAIL reset_bus got %h exp 0", bif.bmbif_xx_req_bus); end
    n_tests++; if (bif.bmbif_xx_mid !== 3'd0) begin n_fail++; $display("FAIL reset_mid got %0d exp 0", bif.bmbif_xx_mid); end
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got %b exp 0000", bif.bmbif_piu_xx_grant); end
    n_tests++; if (bif.bmbif_xx_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", bif.bmbif_xx_idle); end
    n_tests++; if (b3.bmbif_xx_fifo_cnt !== 4'd0) begin n_fail++; $display("FAIL reset3_cnt got %0d exp 0", b3.bmbif_xx_fifo_cnt); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) set_bus(i, 9'h100 + 9'(i * 17));
    bif.piu_bmbif_xx_req = 4'hF;
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (bif.bmbif_piu_xx_grant !== 4'(1 << c)) begin n_fail++; $display("FAIL fill_grant c=%0d got %b exp %b", c, bif.bmbif_piu_xx_grant, 4'(1 << c)); end
      n_tests++; if (bif.bmbif_xx_bar_req !== (c != 0)) begin n_fail++; $display("FAIL fill_bar_req c=%0d got %b exp %b", c, bif.bmbif_xx_bar_req, (c != 0)); end
      n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'(c)) begin n_fail++; $display("FAIL fill_cnt c=%0d got %0d exp %0d", c, bif.bmbif_xx_fifo_cnt, c); end
      step();
      #1;
    end
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b0) begin n_fail++; $display("FAIL full_grant got %b exp 0000", bif.bmbif_piu_xx_grant); end
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt got %0d exp 4", bif.bmbif_xx_fifo_cnt); end
    n_tests++; if (bif.bmbif_xx_mid !== 3'd0 || bif.bmbif_xx_req_bus !== 9'h100) begin n_fail++; $display("FAIL fill_head got mid %0d bus %h exp mid 0 bus 100", bif.bmbif_xx_mid, bif.bmbif_xx_req_bus); end
  endtask

  task automatic test_full();
    logic [2:0] exp_mid [4];
    logic [8:0] exp_bus [4];
    exp_mid = '{3'd1, 3'd2, 3'd3, 3'd2};
    exp_bus = '{9'h111, 9'h122, 9'h133, 9'h122};
    bif.piu_bmbif_xx_req = 4'b0100;
    bif.xx_bmbif_bar_grant = 1'b0;
    #1;
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b0) begin n_fail++; $display("FAIL stall_grant got %b exp 0000", bif.bmbif_piu_xx_grant); end
    step();
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b0 || bif.bmbif_xx_fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL stall_hold got grant %b cnt %0d exp 0000 4", bif.bmbif_piu_xx_grant, bif.bmbif_xx_fifo_cnt); end
    bif.xx_bmbif_bar_grant = 1'b1;
    #1;
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b0100) begin n_fail++; $display("FAIL pop_grant got %b exp 0100", bif.bmbif_piu_xx_grant); end
    step();
    bif.piu_bmbif_xx_req = 4'b0;
    bif.xx_bmbif_bar_grant = 1'b0;
    #1;
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL pop_push_cnt got %0d exp 4", bif.bmbif_xx_fifo_cnt); end
    bif.xx_bmbif_bar_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (bif.bmbif_xx_mid !== exp_mid[k] || bif.bmbif_xx_req_bus !== exp_bus[k]) begin n_fail++; $display("FAIL drain k=%0d got mid %0d bus %h exp mid %0d bus %h", k, bif.bmbif_xx_mid, bif.bmbif_xx_req_bus, exp_mid[k], exp_bus[k]); end
      step();
    end
    bif.xx_bmbif_bar_grant = 1'b0;
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd0 || bif.bmbif_xx_bar_req !== 1'b0) begin n_fail++; $display("FAIL drain_empty got cnt %0d bar_req %b exp 0 0", bif.bmbif_xx_fifo_cnt, bif.bmbif_xx_bar_req); end
    // Last grant went to PIU2, so PIU3 must win next.
    bif.piu_bmbif_xx_req = 4'hF;
    #1;
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b1000) begin n_fail++; $display("FAIL rr_after_pop got %b exp 1000", bif.bmbif_piu_xx_grant); end
    step();
    bif.piu_bmbif_xx_req = 4'b0;
    bif.xx_bmbif_bar_grant = 1'b1;
    #1;
    n_tests++; if (bif.bmbif_xx_mid !== 3'd3) begin n_fail++; $display("FAIL rr_head_mid got %0d exp 3", bif.bmbif_xx_mid); end
    step();
    bif.xx_bmbif_bar_grant = 1'b0;
  endtask

  task automatic test_stream();
    bif.piu_bmbif_xx_req = 4'b1000;
    bif.xx_bmbif_bar_grant = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_bus(3, 9'h030 + 9'(c));
      #1;
      n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b1000) begin n_fail++; $display("FAIL stream_grant c=%0d got %b exp 1000", c, bif.bmbif_piu_xx_grant); end
      n_tests++; if (bif.bmbif_xx_bar_req !== (c != 0) || bif.bmbif_xx_fifo_cnt !== 3'(c != 0)) begin n_fail++; $display("FAIL stream_state c=%0d got bar_req %b cnt %0d exp %b %0d", c, bif.bmbif_xx_bar_req, bif.bmbif_xx_fifo_cnt, (c != 0), (c != 0)); end
      if (c != 0) begin
        n_tests++; if (bif.bmbif_xx_mid !== 3'd3 || bif.bmbif_xx_req_bus !== 9'h030 + 9'(c - 1)) begin n_fail++; $display("FAIL stream_head c=%0d got mid %0d bus %h exp mid 3 bus %h", c, bif.bmbif_xx_mid, bif.bmbif_xx_req_bus, 9'h030 + 9'(c - 1)); end
      end
      step();
    end
    bif.piu_bmbif_xx_req = 4'b0;
    #1;
    n_tests++; if (bif.bmbif_xx_req_bus !== 9'h039) begin n_fail++; $display("FAIL stream_last got %h exp 039", bif.bmbif_xx_req_bus); end
    step();
    bif.xx_bmbif_bar_grant = 1'b0;
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL stream_cnt got %0d exp 0", bif.bmbif_xx_fifo_cnt); end
  endtask

  task automatic test_capture();
    set_bus(0, 9'h055);
    set_bus(1, 9'h1A5);
    bif.piu_bmbif_xx_req = 4'b0011;
    #1;
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b0001) begin n_fail++; $display("FAIL cap_grant0 got %b exp 0001", bif.bmbif_piu_xx_grant); end
    step();
    bif.piu_bmbif_xx_req = 4'b0010;
    #1;
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b0010) begin n_fail++; $display("FAIL cap_grant1 got %b exp 0010", bif.bmbif_piu_xx_grant); end
    step();
    bif.piu_bmbif_xx_req = 4'b0;
    set_bus(1, 9'h000);
    #1;
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd2 || bif.bmbif_xx_mid !== 3'd0 || bif.bmbif_xx_req_bus !== 9'h055) begin n_fail++; $display("FAIL cap_head0 got cnt %0d mid %0d bus %h exp 2 0 055", bif.bmbif_xx_fifo_cnt, bif.bmbif_xx_mid, bif.bmbif_xx_req_bus); end
    bif.xx_bmbif_bar_grant = 1'b1;
    step();
    n_tests++; if (bif.bmbif_xx_mid !== 3'd1 || bif.bmbif_xx_req_bus !== 9'h1A5) begin n_fail++; $display("FAIL cap_head1 got mid %0d bus %h exp 1 1a5", bif.bmbif_xx_mid, bif.bmbif_xx_req_bus); end
    step();
    bif.xx_bmbif_bar_grant = 1'b0;
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd0 || bif.bmbif_xx_idle !== 1'b1) begin n_fail++; $display("FAIL cap_empty got cnt %0d idle %b exp 0 1", bif.bmbif_xx_fifo_cnt, bif.bmbif_xx_idle); end
  endtask

  task automatic test_wrap();
    int p;
    logic [8:0] v;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      p = i % 4;
      v = 9'h0F0 + 9'(i);
      bif.piu_bmbif_xx_req = 4'(1 << p);
      set_bus(p, v);
      bif.xx_bmbif_bar_grant = (i >= 2);
      #1;
      n_tests++; if (bif.bmbif_piu_xx_grant !== 4'(1 << p)) begin n_fail++; $display("FAIL wrap_grant i=%0d got %b exp %b", i, bif.bmbif_piu_xx_grant, 4'(1 << p)); end
      n_tests++; if (bif.bmbif_xx_bar_req !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL wrap_bar_req i=%0d got %b exp %b", i, bif.bmbif_xx_bar_req, (exp_q.size() != 0)); end
      if (bif.xx_bmbif_bar_grant && exp_q.size() != 0) begin
        n_tests++; if ({bif.bmbif_xx_mid, bif.bmbif_xx_req_bus} !== exp_q[0]) begin n_fail++; $display("FAIL wrap_head i=%0d got %h exp %h", i, {bif.bmbif_xx_mid, bif.bmbif_xx_req_bus}, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      exp_q.push_back({3'(p), v});
      step();
    end
    bif.piu_bmbif_xx_req = 4'b0;
    bif.xx_bmbif_bar_grant = 1'b1;
    while (exp_q.size() != 0) begin
      n_tests++; if ({bif.bmbif_xx_mid, bif.bmbif_xx_req_bus} !== exp_q[0]) begin n_fail++; $display("FAIL wrap_drain got %h exp %h", {bif.bmbif_xx_mid, bif.bmbif_xx_req_bus}, exp_q[0]); end
      void'(exp_q.pop_front());
      step();
    end
    bif.xx_bmbif_bar_grant = 1'b0;
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd0 || bif.bmbif_xx_idle !== 1'b1 || bif.bmbif_xx_bar_req !== 1'b0) begin n_fail++; $display("FAIL wrap_end got cnt %0d idle %b bar_req %b exp 0 1 0", bif.bmbif_xx_fifo_cnt, bif.bmbif_xx_idle, bif.bmbif_xx_bar_req); end
  endtask

  task automatic test_reset_mid();
    bif.piu_bmbif_xx_req = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (bif.bmbif_piu_xx_grant !== 4'(1 << c)) begin n_fail++; $display("FAIL rst_fill c=%0d got %b exp %b", c, bif.bmbif_piu_xx_grant, 4'(1 << c)); end
      step();
    end
    bif.piu_bmbif_xx_req = 4'b0;
    #1;
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd3) begin n_fail++; $display("FAIL rst_pre_cnt got %0d exp 3", bif.bmbif_xx_fifo_cnt); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bif.bmbif_xx_bar_req !== 1'b0 || bif.bmbif_xx_req_bus !== 9'h0 || bif.bmbif_xx_fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_async got bar_req %b bus %h cnt %0d exp 0 0 0", bif.bmbif_xx_bar_req, bif.bmbif_xx_req_bus, bif.bmbif_xx_fifo_cnt); end
    step();
    rst_n = 1'b1;
    bif.piu_bmbif_xx_req = 4'hF;
    #1;
    n_tests++; if (bif.bmbif_piu_xx_grant !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant got %b exp 0001", bif.bmbif_piu_xx_grant); end
    step();
    bif.piu_bmbif_xx_req = 4'b0;
    bif.xx_bmbif_bar_grant = 1'b1;
    step();
    bif.xx_bmbif_bar_grant = 1'b0;
    n_tests++; if (bif.bmbif_xx_fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cleanup_cnt got %0d exp 0", bif.bmbif_xx_fifo_cnt); end
  endtask

  task automatic test_p3();
    for (int i = 0; i < 3; i++) b3.piu_bmbif_req_bus[i*16 +: 16] = 16'hA000 + 16'(i);
    b3.piu_bmbif_xx_req = 3'b111;
    b3.xx_bmbif_bar_grant = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++; if (b3.bmbif_piu_xx_grant !== 3'(1 << (c % 3))) begin n_fail++; $display("FAIL p3_grant c=%0d got %b exp %b", c, b3.bmbif_piu_xx_grant, 3'(1 << (c % 3))); end
      if (c != 0) begin
        n_tests++; if (b3.bmbif_xx_mid !== 3'((c - 1) % 3) || b3.bmbif_xx_req_bus !== 16'hA000 + 16'((c - 1) % 3)) begin n_fail++; $display("FAIL p3_head c=%0d got mid %0d bus %h exp mid %0d", c, b3.bmbif_xx_mid, b3.bmbif_xx_req_bus, (c - 1) % 3); end
      end
      step();
    end
    b3.piu_bmbif_xx_req = 3'b0;
    b3.xx_bmbif_bar_grant = 1'b0;
    step();
    n_tests++; if (b3.bmbif_xx_fifo_cnt !== 4'd1) begin n_fail++; $display("FAIL p3_cnt got %0d exp 1", b3.bmbif_xx_fifo_cnt); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (b3.bmbif_xx_bar_req !== 1'b0 || b3.bmbif_xx_req_bus !== 16'h0 || b3.bmbif_xx_fifo_cnt !== 4'd0) begin n_fail++; $display("FAIL p3_rst got bar_req %b bus %h cnt %0d exp 0 0 0", b3.bmbif_xx_bar_req, b3.bmbif_xx_req_bus, b3.bmbif_xx_fifo_cnt); end
    step();
    rst_n = 1'b1;
    b3.piu_bmbif_xx_req = 3'b111;
    #1;
    n_tests++; if (b3.bmbif_piu_xx_grant !== 3'b001) begin n_fail++; $display("FAIL p3_rst_grant got %b exp 001", b3.bmbif_piu_xx_grant); end
    step();
    b3.piu_bmbif_xx_req = 3'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_stream();
    test_capture();
    test_wrap();
    test_reset_mid();
    test_p3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
